// File: rtl/sv32_pkg.sv
// Shared Sv32 definitions for the page-table walker and the TLB.
// PTE bit positions, walker state encoding, the permission field type,
// and the PTE address formation helper.
package sv32_pkg;

  // PTE bit positions
  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_G       = 5;
  localparam int PTE_A       = 6;
  localparam int PTE_D       = 7;
  localparam int PTE_PPN_LSB = 10;

  localparam int PPN_W  = 22;
  localparam int VPN_W  = 20;
  localparam int PERM_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    L1   = 2'd1,
    L0   = 2'd2,
    RESP = 2'd3
  } ptw_state_e;

  // {D,A,G,U,X,W,R}, same layout as PTE[7:1]
  typedef logic [PERM_W-1:0] perm_t;

  // PTE address: 4-byte entries indexed by one VPN slice inside a 4 KiB table.
  // Only the low 20 PPN bits fit the 32-bit physical space.
  function automatic logic [31:0] pte_addr(input logic [19:0] base_ppn,
                                           input logic [9:0]  vpn_slice);
    return {base_ppn, vpn_slice, 2'b00};
  endfunction

endpackage

// File: rtl/sv32_pte_decode.sv
// Combinational Sv32 PTE field decode.
// Splits a raw PTE into the classification bits the walker acts on.
module sv32_pte_decode
  import sv32_pkg::*;
(
  input  logic [31:0]      pte,
  output logic             is_valid,
  output logic             is_leaf,
  output logic             malformed,
  output logic             misaligned,
  output perm_t            perm,
  output logic [PPN_W-1:0] ppn
);

  // RSW bits are software-owned and carry no meaning for the walk
  logic unused_rsw;

  assign is_valid   = pte[PTE_V];
  assign is_leaf    = pte[PTE_R] | pte[PTE_X];
  assign malformed  = pte[PTE_W] & ~pte[PTE_R];
  // a level-1 leaf must have a zero ppn0 to be a naturally aligned 4 MiB page
  assign misaligned = |pte[PTE_PPN_LSB +: 10];
  assign perm       = pte[PTE_D:PTE_R];
  assign ppn        = pte[31:PTE_PPN_LSB];
  assign unused_rsw = ^pte[9:8];

endmodule

// File: rtl/sv32_ptw.sv
// Sv32 hardware page-table walker feeding the TLB fill port.
// Walks up to two levels over a single-outstanding memory read port,
// then issues a one-cycle fill on a valid leaf or reports a fault.
// Optional build macro SV32_PTW_SUPERPAGE_ALIGN_EN: a level-1 leaf with a
// non-zero ppn0 is reported as a page fault instead of being filled.
//
// state | meaning
// IDLE  | ready for a walk request
// L1    | reading the level-1 PTE from the root table
// L0    | reading the level-0 PTE from the table the L1 pointer named
// RESP  | one-cycle completion: done pulse, fault flags, optional fill
module sv32_ptw
  import sv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             walk_valid_i,
  output logic             walk_ready_o,
  input  logic [31:0]      walk_vaddr_i,
  input  logic [PPN_W-1:0] satp_ppn_i,
  input  logic             flush_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_err_i,
  output logic             fill_req_o,
  output logic [VPN_W-1:0] fill_vpn_o,
  output logic [PPN_W-1:0] fill_ppn_o,
  output perm_t            fill_perm_o,
  output logic             fill_superpage_o,
  output logic             done_o,
  output logic             page_fault_o,
  output logic             access_fault_o
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LOAD =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  ptw_state_e       state;
  logic [VPN_W-1:0] vpn_q;
  logic             squash_q;
  logic [TW-1:0]    tmr_q;

  logic             fill_q;
  logic [VPN_W-1:0] fill_vpn_q;
  logic [PPN_W-1:0] fill_ppn_q;
  perm_t            fill_perm_q;
  logic             fill_sp_q;

  logic             pte_valid;
  logic             pte_leaf;
  logic             pte_malformed;
  logic             pte_misaligned;
  perm_t            pte_perm;
  logic [PPN_W-1:0] pte_ppn;

  logic             walk_pf;
  logic             descend;
  logic             timed_out;
  logic             squash_now;
  logic             unused_bits;

  sv32_pte_decode u_dec (
    .pte        (mem_rdata_i),
    .is_valid   (pte_valid),
    .is_leaf    (pte_leaf),
    .malformed  (pte_malformed),
    .misaligned (pte_misaligned),
    .perm       (pte_perm),
    .ppn        (pte_ppn)
  );

  assign timed_out  = (TIMEOUT_CYCLES != 0) && (tmr_q == '0);
  assign squash_now = squash_q | flush_i;
  assign descend    = pte_valid & ~pte_malformed & ~pte_leaf & (state == L1);

  // Page-fault classification of the PTE returned in the ack cycle
  always_comb begin
    walk_pf = ~pte_valid | pte_malformed | (~pte_leaf & (state == L0));
`ifdef SV32_PTW_SUPERPAGE_ALIGN_EN
    if (pte_valid && pte_leaf && (state == L1) && pte_misaligned) begin
      walk_pf = 1'b1;
    end
`endif
  end

`ifdef SV32_PTW_SUPERPAGE_ALIGN_EN
  assign unused_bits = ^{satp_ppn_i[21:20], walk_vaddr_i[11:0]};
`else
  // ppn0 of a superpage passes through to the TLB, which ignores it
  assign unused_bits = ^{satp_ppn_i[21:20], walk_vaddr_i[11:0], pte_misaligned};
`endif

  // Walker FSM with registered memory, completion and fill outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vpn_q          <= '0;
      squash_q       <= 1'b0;
      tmr_q          <= '0;
      walk_ready_o   <= 1'b1;
      mem_req_o      <= 1'b0;
      mem_addr_o     <= '0;
      done_o         <= 1'b0;
      page_fault_o   <= 1'b0;
      access_fault_o <= 1'b0;
      fill_q         <= 1'b0;
      fill_vpn_q     <= '0;
      fill_ppn_q     <= '0;
      fill_perm_q    <= '0;
      fill_sp_q      <= 1'b0;
    end else begin
      done_o         <= 1'b0;
      page_fault_o   <= 1'b0;
      access_fault_o <= 1'b0;
      fill_q         <= 1'b0;
      fill_vpn_q     <= '0;
      fill_ppn_q     <= '0;
      fill_perm_q    <= '0;
      fill_sp_q      <= 1'b0;

      case (state)
        IDLE: begin
          if (walk_valid_i) begin
            vpn_q        <= walk_vaddr_i[31:12];
            squash_q     <= flush_i;
            walk_ready_o <= 1'b0;
            mem_req_o    <= 1'b1;
            mem_addr_o   <= pte_addr(satp_ppn_i[19:0], walk_vaddr_i[31:22]);
            tmr_q        <= TMR_LOAD;
            state        <= L1;
          end
        end

        L1, L0: begin
          if (flush_i) begin
            squash_q <= 1'b1;
          end
          if (mem_ack_i) begin
            if (!mem_err_i && descend) begin
              // pointer at level 1: request stays up, address moves to the L0 table
              mem_addr_o <= pte_addr(pte_ppn[19:0], vpn_q[9:0]);
              tmr_q      <= TMR_LOAD;
              state      <= L0;
            end else begin
              mem_req_o      <= 1'b0;
              mem_addr_o     <= '0;
              done_o         <= 1'b1;
              access_fault_o <= mem_err_i;
              page_fault_o   <= ~mem_err_i & walk_pf;
              state          <= RESP;
              if (!mem_err_i && !walk_pf && !squash_now) begin
                fill_q      <= 1'b1;
                fill_vpn_q  <= vpn_q;
                fill_ppn_q  <= pte_ppn;
                fill_perm_q <= pte_perm;
                fill_sp_q   <= (state == L1);
              end
            end
          end else if (timed_out) begin
            mem_req_o      <= 1'b0;
            mem_addr_o     <= '0;
            done_o         <= 1'b1;
            access_fault_o <= 1'b1;
            state          <= RESP;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end

        RESP: begin
          squash_q     <= 1'b0;
          walk_ready_o <= 1'b1;
          state        <= IDLE;
        end

        default: begin
          state        <= IDLE;
          walk_ready_o <= 1'b1;
          mem_req_o    <= 1'b0;
        end
      endcase
    end
  end

  // A flush landing in the RESP cycle itself still suppresses the fill
  assign fill_req_o       = fill_q & ~flush_i;
  assign fill_vpn_o       = fill_req_o ? fill_vpn_q  : '0;
  assign fill_ppn_o       = fill_req_o ? fill_ppn_q  : '0;
  assign fill_perm_o      = fill_req_o ? fill_perm_q : '0;
  assign fill_superpage_o = fill_req_o & fill_sp_q;

endmodule

// File: tb/tb_sv32_ptw.sv
// Directed scoreboard bench for sv32_ptw (walker built with an 8-cycle timeout).
module tb_sv32_ptw;

  typedef struct packed {
    logic        pf;
    logic        af;
    logic        fill;
    logic [19:0] vpn;
    logic [21:0] ppn;
    logic [6:0]  perm;
    logic        sp;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        walk_valid_i;
  logic        walk_ready_o;
  logic [31:0] walk_vaddr_i;
  logic [21:0] satp_ppn_i;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        fill_req_o;
  logic [19:0] fill_vpn_o;
  logic [21:0] fill_ppn_o;
  logic [6:0]  fill_perm_o;
  logic        fill_superpage_o;
  logic        done_o;
  logic        page_fault_o;
  logic        access_fault_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t_acc = 0;

  logic [31:0] addr_q[$];
  resp_t       exp_q[$];

  sv32_ptw #(.TIMEOUT_CYCLES(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .walk_valid_i     (walk_valid_i),
    .walk_ready_o     (walk_ready_o),
    .walk_vaddr_i     (walk_vaddr_i),
    .satp_ppn_i       (satp_ppn_i),
    .flush_i          (flush_i),
    .mem_req_o        (mem_req_o),
    .mem_addr_o       (mem_addr_o),
    .mem_ack_i        (mem_ack_i),
    .mem_rdata_i      (mem_rdata_i),
    .mem_err_i        (mem_err_i),
    .fill_req_o       (fill_req_o),
    .fill_vpn_o       (fill_vpn_o),
    .fill_ppn_o       (fill_ppn_o),
    .fill_perm_o      (fill_perm_o),
    .fill_superpage_o (fill_superpage_o),
    .done_o           (done_o),
    .page_fault_o     (page_fault_o),
    .access_fault_o   (access_fault_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic resp_t mk(input logic pf, input logic af, input logic fill,
                               input logic [19:0] vpn, input logic [21:0] ppn,
                               input logic [6:0] perm, input logic sp);
    resp_t r;
    r.pf = pf; r.af = af; r.fill = fill; r.vpn = vpn; r.ppn = ppn; r.perm = perm; r.sp = sp;
    return r;
  endfunction

  task automatic start_walk(input string tag, input logic [31:0] va,
                            input logic [21:0] satp, input logic fl);
    chk({tag, "_ready"}, walk_ready_o, 1);
    walk_valid_i = 1'b1;
    walk_vaddr_i = va;
    satp_ppn_i   = satp;
    flush_i      = fl;
    t_acc        = cyc;
    @(negedge clk);
    walk_valid_i = 1'b0;
    flush_i      = 1'b0;
  endtask

  task automatic serve(input string tag, input logic [31:0] pte, input logic err,
                       input int waits, input logic fl);
    logic [31:0] a;
    a = 'x;
    for (int i = 0; i < 20 && !mem_req_o; i++) @(negedge clk);
    chk({tag, "_req"}, mem_req_o, 1);
    if (addr_q.size() > 0) a = addr_q.pop_front();
    chk({tag, "_addr"}, mem_addr_o, a);
    for (int w = 0; w < waits; w++) begin
      flush_i = fl && (w == 0);
      @(negedge clk);
      flush_i = 1'b0;
      chk({tag, "_hold"}, {mem_req_o, mem_addr_o}, {1'b1, a});
    end
    mem_ack_i   = 1'b1;
    mem_rdata_i = pte;
    mem_err_i   = err;
    @(negedge clk);
    mem_ack_i   = 1'b0;
    mem_err_i   = 1'b0;
    mem_rdata_i = '0;
  endtask

  task automatic wait_done(input string tag, input int lat);
    resp_t e;
    e = 'x;
    for (int i = 0; i < 40 && !done_o; i++) @(negedge clk);
    chk({tag, "_done"}, done_o, 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk({tag, "_pf"},   page_fault_o,     e.pf);
    chk({tag, "_af"},   access_fault_o,   e.af);
    chk({tag, "_fill"}, fill_req_o,       e.fill);
    chk({tag, "_vpn"},  fill_vpn_o,       e.vpn);
    chk({tag, "_ppn"},  fill_ppn_o,       e.ppn);
    chk({tag, "_perm"}, fill_perm_o,      e.perm);
    chk({tag, "_sp"},   fill_superpage_o, e.sp);
    chk({tag, "_noreq"}, mem_req_o, 0);
    if (lat >= 0) chk({tag, "_lat"}, cyc - t_acc, lat);
    @(negedge clk);
    chk({tag, "_pulse"}, {done_o, fill_req_o, walk_ready_o}, 3'b001);
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    walk_valid_i = 1'b0;
    walk_vaddr_i = '0;
    satp_ppn_i   = '0;
    flush_i      = 1'b0;
    mem_ack_i    = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", walk_ready_o, 1);
    chk("rst_outs", {mem_req_o, done_o, fill_req_o, page_fault_o, access_fault_o}, 5'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // two-level walk, zero-wait acks
    addr_q.push_back(32'h0008_0004);
    addr_q.push_back(32'h8000_0004);
    exp_q.push_back(mk(0, 0, 1, 20'h00401, 22'h048D14, 7'h67, 0));
    start_walk("t1", 32'h0040_1234, 22'h00080, 0);
    serve("t1_l1", 32'h2000_0001, 0, 0, 0);
    serve("t1_l0", 32'h1234_50CF, 0, 0, 0);
    wait_done("t1", 3);

    // superpage leaf, one read, minimum latency
    addr_q.push_back(32'h0008_0004);
    exp_q.push_back(mk(0, 0, 1, 20'h00401, 22'h080000, 7'h67, 1));
    start_walk("t2", 32'h0040_1234, 22'h00080, 0);
    serve("t2_l1", 32'h2000_00CF, 0, 0, 0);
    wait_done("t2", 2);

    // superpage leaf after memory wait, top PPN bits pass to the fill
    addr_q.push_back(32'hABCD_EFFC);
    exp_q.push_back(mk(0, 0, 1, 20'hFFC03, 22'h200000, 7'h05, 1));
    start_walk("t2b", 32'hFFC0_3000, 22'h2ABCDE, 0);
    serve("t2b_l1", 32'h8000_000B, 0, 3, 0);
    wait_done("t2b", -1);

    // W without R at level 1
    addr_q.push_back(32'h0008_0004);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    start_walk("t3a", 32'h0040_1234, 22'h00080, 0);
    serve("t3a_l1", 32'h0000_0004, 0, 0, 0);
    wait_done("t3a", -1);

    // pointer at level 0
    addr_q.push_back(32'h0008_0004);
    addr_q.push_back(32'h8000_0004);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    start_walk("t3b", 32'h0040_1234, 22'h00080, 0);
    serve("t3b_l1", 32'h2000_0001, 0, 0, 0);
    serve("t3b_l0", 32'h2000_0001, 0, 0, 0);
    wait_done("t3b", -1);

    // invalid PTE
    addr_q.push_back(32'h0008_0004);
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    start_walk("t3c", 32'h0040_1234, 22'h00080, 0);
    serve("t3c_l1", 32'h2000_00CE, 0, 0, 0);
    wait_done("t3c", -1);

    // bus error wins over a good-looking leaf
    addr_q.push_back(32'h0008_0004);
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    start_walk("t3d", 32'h0040_1234, 22'h00080, 0);
    serve("t3d_l1", 32'h2000_00CF, 1, 1, 0);
    wait_done("t3d", -1);

    // timeout with no ack, then a late ack that must be ignored
    exp_q.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    start_walk("t4", 32'h0040_1234, 22'h00080, 0);
    chk("t4_addr", mem_addr_o, 32'h0008_0004);
    n = 0;
    while (mem_req_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("t4_req_cycles", n, 8);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h2000_00CF;
    wait_done("t4", -1);
    @(negedge clk);
    chk("t4_late_ack", {done_o, fill_req_o, mem_req_o}, 3'b000);
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    @(negedge clk);

    // flush during the L0 wait squashes the fill only
    addr_q.push_back(32'h0008_0004);
    addr_q.push_back(32'h8000_0004);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    start_walk("t5a", 32'h0040_1234, 22'h00080, 0);
    serve("t5a_l1", 32'h2000_0001, 0, 0, 0);
    serve("t5a_l0", 32'h1234_50CF, 0, 2, 1);
    wait_done("t5a", -1);

    // flush on the accept cycle
    addr_q.push_back(32'h0008_0004);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    start_walk("t5b", 32'h0040_1234, 22'h00080, 1);
    serve("t5b_l1", 32'h2000_00CF, 0, 0, 0);
    wait_done("t5b", -1);

    // squash clears on return to idle: next walk fills again
    addr_q.push_back(32'h0008_0004);
    exp_q.push_back(mk(0, 0, 1, 20'h00401, 22'h080000, 7'h67, 1));
    start_walk("t5c", 32'h0040_1234, 22'h00080, 0);
    // request while busy is ignored
    walk_valid_i = 1'b1;
    walk_vaddr_i = 32'hFFFF_F000;
    chk("t5c_busy_ready", walk_ready_o, 0);
    @(negedge clk);
    walk_valid_i = 1'b0;
    serve("t5c_l1", 32'h2000_00CF, 0, 0, 0);
    wait_done("t5c", -1);
    @(negedge clk);
    chk("t5c_no_queue", mem_req_o, 0);

    // reset mid-L1
    start_walk("t5d", 32'h0040_1234, 22'h00080, 0);
    chk("t5d_inflight", mem_req_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5d_rst_now", {walk_ready_o, mem_req_o, done_o}, 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // misaligned superpage leaf
    addr_q.push_back(32'h0008_0004);
`ifdef SV32_PTW_SUPERPAGE_ALIGN_EN
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
`else
    exp_q.push_back(mk(0, 0, 1, 20'h00401, 22'h000001, 7'h67, 1));
`endif
    start_walk("t6", 32'h0040_1234, 22'h00080, 0);
    serve("t6_l1", 32'h0000_04CF, 0, 0, 0);
    wait_done("t6", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
